// File: rtl/data_byte_emitter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_byte_emitter_pkg                                     |
// | Brief    : Shared widths, state encoding, order constants and the    |
// |            load-time word alignment helper for the byte emitter.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package data_byte_emitter_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic ORD_MSB = 1'b0;
  localparam logic ORD_LSB = 1'b1;

  // Pre-align the word so the first byte to emit sits in the output slot
  // for its order: MSB-first moves byte (count) up to [31:24], LSB-first
  // already has byte 0 in [7:0].
  function automatic logic [WORD_W-1:0] align_word(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        count,
    input logic              order
  );
    logic [WORD_W-1:0] aligned;
    if (order == ORD_LSB) begin
      aligned = word;
    end else begin
      case (count)
        2'b00:   aligned = {word[7:0],  24'h00_0000};
        2'b01:   aligned = {word[15:0], 16'h0000};
        2'b10:   aligned = {word[23:0], 8'h00};
        default: aligned = word;
      endcase
    end
    return aligned;
  endfunction

endpackage : data_byte_emitter_pkg
`default_nettype wire

// File: rtl/data_byte_emitter_byte_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_byte_emitter_byte_shift_reg                          |
// | Brief    : Word register with parallel load and byte-wide shift      |
// |            left or right; exposes the top and bottom byte slots.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module data_byte_emitter_byte_shift_reg
  import data_byte_emitter_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              shift,
  input  logic              shift_right,
  output logic [BYTE_W-1:0] msb_byte,
  output logic [BYTE_W-1:0] lsb_byte
);

  logic [WORD_W-1:0] r_word;

  // Load has priority; shifting moves the next byte into the active slot
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_word <= '0;
    end else if (load) begin
      r_word <= load_word;
    end else if (shift) begin
      if (shift_right) begin
        r_word <= {{BYTE_W{1'b0}}, r_word[WORD_W-1:BYTE_W]};
      end else begin
        r_word <= {r_word[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end
    end
  end

  assign msb_byte = r_word[WORD_W-1:WORD_W-BYTE_W];
  assign lsb_byte = r_word[BYTE_W-1:0];

endmodule : data_byte_emitter_byte_shift_reg
`default_nettype wire

// File: rtl/data_byte_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_byte_emitter                                         |
// | Brief    : Emits 1-4 bytes of a captured word, MSB- or LSB-first,    |
// |            over a valid/ready handshake toward the memory write port.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module data_byte_emitter
  import data_byte_emitter_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [WORD_W-1:0] Word,
  input  logic [1:0]        Count,
  input  logic              Order,
  output logic              Busy,
  output logic [BYTE_W-1:0] ByteOut,
  output logic              ByteValid,
  input  logic              ByteReady,
  output logic              Done
);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_order;
  logic              r_busy;
  logic              r_valid;
  logic              r_done;

  logic              w_load;
  logic              w_handshake;
  logic              w_shift;
  logic [WORD_W-1:0] w_aligned;
  logic [BYTE_W-1:0] w_msb_byte;
  logic [BYTE_W-1:0] w_lsb_byte;

  assign w_load      = (r_state == IDLE) && Load;
  assign w_handshake = (r_state == SEND) && r_valid && ByteReady;
  // The last byte is not shifted out; the register simply idles afterwards
  assign w_shift     = w_handshake && (r_cnt != 2'd0);
  assign w_aligned   = align_word(Word, Count, Order);

  data_byte_emitter_byte_shift_reg u_byte_shift_reg (
    .Clock       (Clock),
    .Reset       (Reset),
    .load        (w_load),
    .load_word   (w_aligned),
    .shift       (w_shift),
    .shift_right (r_order),
    .msb_byte    (w_msb_byte),
    .lsb_byte    (w_lsb_byte)
  );

  // Transfer control: capture in IDLE, count accepted bytes in SEND,
  // one-cycle Done pulse, then back to IDLE
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_order <= ORD_MSB;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (Load) begin
            r_state <= SEND;
            r_cnt   <= Count;
            r_order <= Order;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        SEND: begin
          if (r_valid && ByteReady) begin
            if (r_cnt != 2'd0) begin
              r_cnt <= r_cnt - 2'd1;
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 2'd0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = r_busy;
  assign ByteValid = r_valid;
  assign Done      = r_done;
  // Output slot is fixed per order; forced to zero when nothing is offered
  assign ByteOut   = !r_valid ? '0 :
                     (r_order == ORD_LSB) ? w_lsb_byte : w_msb_byte;

endmodule : data_byte_emitter
`default_nettype wire

// File: tb/tb_data_byte_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_data_byte_emitter                                      |
// | Brief    : Self-checking bench for data_byte_emitter: directed cases |
// |            plus randomized transfers against a byte-list model.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_data_byte_emitter;

  logic        Clock;
  logic        Reset;
  logic        Load;
  logic [31:0] Word;
  logic [1:0]  Count;
  logic        Order;
  logic        Busy;
  logic [7:0]  ByteOut;
  logic        ByteValid;
  logic        ByteReady;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  data_byte_emitter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Load      (Load),
    .Word      (Word),
    .Count     (Count),
    .Order     (Order),
    .Busy      (Busy),
    .ByteOut   (ByteOut),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .Done      (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer. mode: 0 = always ready, 1 = random ready,
  // 2 = hold ready low for 3 cycles on the first byte.
  task automatic xfer(input logic [31:0] w, input logic [1:0] c, input logic o,
                      input int mode, input bit inject, input bit load_in_done);
    logic [7:0]  exp_q[$];
    logic [31:0] asm;
    logic [7:0]  obs;
    int          n;
    int          idx;
    int          cyc;
    int          stall;
    bit          rdy;
    n     = int'(c) + 1;
    asm   = '0;
    idx   = 0;
    cyc   = 0;
    stall = 0;
    // Model: list of the low n bytes in emission order
    for (int i = 0; i < n; i++) begin
      if (o) exp_q.push_back(w[8*i +: 8]);
      else   exp_q.push_back(w[8*(n-1-i) +: 8]);
    end
    Load = 1'b1; Word = w; Count = c; Order = o;
    @(posedge Clock); #1;
    Load = 1'b0; Word = $urandom; Count = 2'($urandom_range(0, 3)); Order = 1'($urandom_range(0, 1));
    while (idx < n && cyc < 200) begin
      obs = ByteOut;
      chk("busy", {31'd0, Busy}, 32'd1);
      chk("valid", {31'd0, ByteValid}, 32'd1);
      chk("byte", {24'd0, obs}, {24'd0, exp_q[idx]});
      chk("done_early", {31'd0, Done}, 32'd0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 99) < 65);
        default: begin
          if (idx == 0 && stall < 3) begin rdy = 1'b0; stall++; end
          else rdy = 1'b1;
        end
      endcase
      if (inject && idx >= 1) begin Load = 1'b1; Word = 32'hFFFF_FFFF; end
      else Load = 1'b0;
      ByteReady = rdy;
      @(posedge Clock); #1;
      if (rdy) begin
        asm = o ? {obs, asm[31:8]} : {asm[23:0], obs};
        idx++;
      end
      cyc++;
    end
    Load = 1'b0;
    ByteReady = 1'b0;
    if (idx < n) begin
      chk("timeout", idx, n);
      return;
    end
    if (mode == 0) chk("latency", cyc, n);
    chk("done_pulse", {31'd0, Done}, 32'd1);
    chk("busy_in_done", {31'd0, Busy}, 32'd1);
    chk("valid_low", {31'd0, ByteValid}, 32'd0);
    ByteReady = 1'($urandom_range(0, 1));
    Load = load_in_done; Word = 32'hFFFF_FFFF;
    @(posedge Clock); #1;
    Load = 1'b0;
    chk("done_clear", {31'd0, Done}, 32'd0);
    chk("busy_idle", {31'd0, Busy}, 32'd0);
    chk("valid_idle", {31'd0, ByteValid}, 32'd0);
    if (n == 4) chk("reassemble", asm, w);
    ByteReady = 1'($urandom_range(0, 1));
    @(posedge Clock); #1;
    chk("idle_hold", {29'd0, Busy, ByteValid, Done}, 32'd0);
    ByteReady = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Load = 1'b0; Word = '0; Count = '0; Order = 1'b0; ByteReady = 1'b0;
    #1;
    chk("reset_outs", {21'd0, Busy, ByteValid, Done, ByteOut}, 32'd0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b1;
    ByteReady = 1'b1;
    @(posedge Clock); #1;
    chk("idle_ready_noeffect", {29'd0, Busy, ByteValid, Done}, 32'd0);
    ByteReady = 1'b0;

    xfer(32'h1122_3344, 2'b11, 1'b0, 0, 1'b0, 1'b0);
    xfer(32'h1122_3344, 2'b11, 1'b1, 0, 1'b0, 1'b0);
    xfer(32'hAABB_CCDD, 2'b01, 1'b0, 2, 1'b0, 1'b1);
    xfer(32'h1122_3344, 2'b11, 1'b0, 0, 1'b1, 1'b0);
    xfer(32'h1122_3344, 2'b11, 1'b1, 1, 1'b1, 1'b1);
    xfer(32'h0000_00A5, 2'b00, 1'b0, 0, 1'b0, 1'b0);
    xfer(32'h0000_00A5, 2'b00, 1'b1, 0, 1'b0, 1'b0);

    // Reset in the middle of a 4-byte transfer
    Load = 1'b1; Word = 32'h5566_7788; Count = 2'b11; Order = 1'b0; ByteReady = 1'b1;
    @(posedge Clock); #1;
    Load = 1'b0;
    chk("mr_b0", {24'd0, ByteOut}, 32'h55);
    @(posedge Clock); #1;
    chk("mr_b1", {24'd0, ByteOut}, 32'h66);
    @(posedge Clock); #1;
    chk("mr_b2", {24'd0, ByteOut}, 32'h77);
    #2 Reset = 1'b0;
    #1;
    chk("mr_async_outs", {21'd0, Busy, ByteValid, Done, ByteOut}, 32'd0);
    ByteReady = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
      chk("mr_no_done", {29'd0, Busy, ByteValid, Done}, 32'd0);
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("mr_after_release", {29'd0, Busy, ByteValid, Done}, 32'd0);
    xfer(32'h5566_7788, 2'b11, 1'b0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      xfer($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_data_byte_emitter
`default_nettype wire
